regfile_sb: RTL and testbench
=============================

# regfile_sb

- Parametrised register file for the pipeline CPU, replacing the fixed 32×32, 2-read/1-write file.
- Adds a configurable read-port count, two write-back ports with a defined collision priority, and same-cycle write-to-read bypass.
- Adds a hardwired zero register, an asynchronous clear, and a per-register busy scoreboard that the decode stage uses for stall decisions.
- Sits between decode (read, issue) and the two write-back sources (ALU and memory).

## Interface

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers; power of two, ≥ 2
- ADDR_W, $clog2(NUM_REGS), address width (derived, do not override)
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, when 1 register 0 reads as zero and is never written or marked busy

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- rd_busy_o  out  NUM_RD  scoreboard busy for each read address, after bypass
- wa_en_i  in  1  write port A enable (ALU write-back)
- wa_addr_i  in  ADDR_W  write port A address
- wa_data_i  in  DATA_W  write port A data
- wb_en_i  in  1  write port B enable (memory write-back)
- wb_addr_i  in  ADDR_W  write port B address
- wb_data_i  in  DATA_W  write port B data
- iss_en_i  in  1  issue: marks the destination register busy
- iss_addr_i  in  ADDR_W  issue destination address
- busy_cnt_o  out  ADDR_W+1  number of registers currently busy

## Operation

- **Storage and busy bits:** registers `mem[NUM_REGS]` and bits `busy[NUM_REGS]`, all updated on the rising edge of clk_i.
- **Write:** each enabled port writes its data at the clock edge.
  - If A and B target the same address, B wins.
  - The write clears `busy[addr]`.
- **Issue:** iss_en_i sets `busy[iss_addr_i]` at the clock edge.
  - If the same address is also written in that cycle, issue wins and busy stays 1, because a new producer is now pending.
- **Zero register (ZERO_REG=1):**
  - Writes and issues to address 0 are ignored.
  - Reads of address 0 return 0 with busy 0, including any bypass case.
- **Read, combinational, per port k:**
  - If wb_en_i and the address equals wb_addr_i: return wb_data_i.
  - Else if wa_en_i and the address equals wa_addr_i: return wa_data_i.
  - Else: return `mem[addr]`.
- **rd_busy_o[k]:** `busy[addr]` AND NOT (a same-cycle write from either port to addr). The issue input does not affect rd_busy_o in the same cycle.
- **busy_cnt_o:** registered population count of `busy`, maintained incrementally.
  - Add 1 when an issue sets a bit that was 0.
  - Subtract 1 when a write clears a bit that was 1 and that bit is not re-issued in the same cycle.
  - Net change per cycle is −2..+1, and the count never wraps.
- **Reset:** while rst_i is high, all `mem` = 0, all `busy` = 0, busy_cnt_o = 0. rd_data_o and rd_busy_o are forced to 0 and the bypass is suppressed.
- **Reset release:** writes and issues arriving in the first cycle after rst_i deasserts take effect at the next edge.

## Timing

- Read latency is 0 cycles (combinational).
- Write latency is 1 edge; the bypass makes written data visible in the same cycle.
- An issue at edge n makes rd_busy_o = 1 for that address from cycle n+1.
- A write at edge n gives rd_busy_o = 0 during cycle n (bypass) and from n+1 onward.
- busy_cnt_o reflects busy bits as of the most recent edge.
- Asserting reset mid-cycle clears everything immediately; in-flight writes and issues in that cycle are dropped.
- No handshake: all enables are single-cycle qualifiers.

## Structure

- Shared package `cpu_pkg` holds:
  - `REG_DATA_W` = 32 and `REG_NUM` = 32 defaults
  - `reg_addr_t` and `reg_data_t` typedefs
  - `ZERO_REG_IDX` = 0
- Sub-module `regfile_rd_port`: one instance per read port, generated NUM_RD times. It takes an address, the two write-port triples, `mem` read data and the busy bit, and outputs data and busy with the bypass, zero-register and reset masking applied.
- The top level owns the `mem` array, the `busy` vector and the counter.

## Test plan

Defaults for all scenarios: DATA_W=32, NUM_REGS=32, NUM_RD=2, ZERO_REG=1.

- **Reset clear:** write 0xDEADBEEF to r5, assert rst_i asynchronously mid-cycle → rd_data_o for r5 = 0 immediately, busy_cnt_o = 0; after release, r5 still reads 0.
- **Bypass and collision priority:** wa = (r7, 0x11), wb = (r7, 0x22) in the same cycle, read port 0 = r7 → 0x22 in that cycle; after the edge r7 = 0x22.
- **Zero register:**
  - write 0x55 to r0 and issue r0 → read r0 = 0, rd_busy_o = 0, busy_cnt_o unchanged.
  - With ZERO_REG=0, the same write reads back 0x55.
- **Scoreboard lifecycle:**
  - issue r3 → next cycle rd_busy_o = 1, busy_cnt_o = 1.
  - wa writes r3 = 0x99 → same cycle busy = 0 and data = 0x99; next cycle busy_cnt_o = 0.
- **Simultaneous events:**
  - busy r4 and r9, then in one cycle: issue r4, wa writes r4, wb writes r9 → after the edge r4 busy, r9 free, busy_cnt_o = 1.
  - Then write r4 and r9 together with no issue → busy_cnt_o = 0, no underflow.
- **Capacity:** issue r1..r31 on 31 consecutive cycles → busy_cnt_o = 31; clear all 31 via both ports (two per cycle) → busy_cnt_o = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file defaults and common register typedefs.
package cpu_pkg;

    localparam int unsigned REG_DATA_W   = 32;
    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_ADDR_W   = $clog2(REG_NUM);
    localparam int unsigned ZERO_REG_IDX = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational register file read port: write-back bypass, zero-register and reset masking.
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wa_en_i,
    input  logic [ADDR_W-1:0] wa_addr_i,
    input  logic [DATA_W-1:0] wa_data_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              busy_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    always_comb begin
        rd_data_o = mem_data_i;
        rd_busy_o = busy_i;
        // Port B is checked first so it wins an A/B collision, matching the stored result.
        if (wb_en_i && (addr_i == wb_addr_i)) begin
            rd_data_o = wb_data_i;
            rd_busy_o = 1'b0;
        end else if (wa_en_i && (addr_i == wa_addr_i)) begin
            rd_data_o = wa_data_i;
            rd_busy_o = 1'b0;
        end
        if (rst_i || (ZERO_EN && (addr_i == ADDR_W'(ZERO_REG_IDX)))) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with dual write-back, bypassed read ports and a busy scoreboard.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned NUM_REGS = REG_NUM,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wa_en_i,
    input  logic [ADDR_W-1:0]        wa_addr_i,
    input  logic [DATA_W-1:0]        wa_data_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam bit          ZERO_EN = (ZERO_REG != 0);
    localparam int unsigned CNT_W   = ADDR_W + 1;

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_busy_cnt;

    logic [NUM_REGS-1:0] w_busy_d;
    logic [CNT_W-1:0]    w_busy_cnt_d;
    logic                w_wa_we;
    logic                w_wb_we;
    logic                w_iss_we;
    logic                w_inc;
    logic                w_dec_a;
    logic                w_dec_b;

    // Effective enables: anything aimed at the hardwired zero register is dropped.
    assign w_wa_we  = wa_en_i  && !(ZERO_EN && (wa_addr_i  == ADDR_W'(ZERO_REG_IDX)));
    assign w_wb_we  = wb_en_i  && !(ZERO_EN && (wb_addr_i  == ADDR_W'(ZERO_REG_IDX)));
    assign w_iss_we = iss_en_i && !(ZERO_EN && (iss_addr_i == ADDR_W'(ZERO_REG_IDX)));

    always_comb begin
        w_busy_d = r_busy;
        if (w_wa_we) begin
            w_busy_d[wa_addr_i] = 1'b0;
        end
        if (w_wb_we) begin
            w_busy_d[wb_addr_i] = 1'b0;
        end
        if (w_iss_we) begin
            w_busy_d[iss_addr_i] = 1'b1;
        end
    end

    // B's clear is not counted again when A already clears the same bit.
    assign w_inc   = w_iss_we && !r_busy[iss_addr_i];
    assign w_dec_a = w_wa_we && r_busy[wa_addr_i] && !(w_iss_we && (iss_addr_i == wa_addr_i));
    assign w_dec_b = w_wb_we && r_busy[wb_addr_i] && !(w_iss_we && (iss_addr_i == wb_addr_i))
                     && !(w_wa_we && (wa_addr_i == wb_addr_i));

    assign w_busy_cnt_d = r_busy_cnt + CNT_W'(w_inc) - CNT_W'(w_dec_a) - CNT_W'(w_dec_b);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wa_we) begin
                r_mem[wa_addr_i] <= wa_data_i;
            end
            // Later assignment takes effect, so B wins an address collision.
            if (w_wb_we) begin
                r_mem[wb_addr_i] <= wb_data_i;
            end
            r_busy     <= w_busy_d;
            r_busy_cnt <= w_busy_cnt_d;
        end
    end

    assign busy_cnt_o = r_busy_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .rst_i      (rst_i),
            .addr_i     (w_addr),
            .wa_en_i    (w_wa_we),
            .wa_addr_i  (wa_addr_i),
            .wa_data_i  (wa_data_i),
            .wb_en_i    (w_wb_we),
            .wb_addr_i  (wb_addr_i),
            .wb_data_i  (wb_data_i),
            .mem_data_i (r_mem[w_addr]),
            .busy_i     (r_busy[w_addr]),
            .rd_data_o  (rd_data_o[k*DATA_W +: DATA_W]),
            .rd_busy_o  (rd_busy_o[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; a second instance runs with ZERO_REG=0.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  busy_cnt;

    logic [63:0] nz_rd_data;
    logic [1:0]  nz_rd_busy;
    logic [5:0]  nz_busy_cnt;

    int checks;
    int failures;

    regfile_sb #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wa_en_i    (wa_en),
        .wa_addr_i  (wa_addr),
        .wa_data_i  (wa_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_cnt_o (busy_cnt)
    );

    regfile_sb #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .ZERO_REG (0)
    ) dut_nz (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (nz_rd_data),
        .rd_busy_o  (nz_rd_busy),
        .wa_en_i    (wa_en),
        .wa_addr_i  (wa_addr),
        .wa_data_i  (wa_data),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_cnt_o (nz_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rd_addr  = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        set_rd(5'd5, 5'd3);
        #1;
        chk("reset_cnt", 32'(busy_cnt), 32'd0);
        chk("reset_rd0", rd_data[31:0], 32'd0);
        chk("reset_busy", 32'(rd_busy), 32'd0);

        // Reset clear: load r5, mark r6 busy, then reset mid-cycle.
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        idle();
        #1;
        chk("pre_rst_r5", rd_data[31:0], 32'hDEADBEEF);
        chk("pre_rst_cnt", 32'(busy_cnt), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_r5", rd_data[31:0], 32'd0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1;
        #1;
        chk("rst_no_bypass", rd_data[31:0], 32'd0);
        wa_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_rd(5'd5, 5'd8);
        wa_en = 1'b1; wa_addr = 5'd8; wa_data = 32'h88;
        tick();
        idle();
        #1;
        chk("post_rst_r5", rd_data[31:0], 32'd0);
        chk("post_rst_r8", rd_data[63:32], 32'h88);
        chk("post_rst_cnt", 32'(busy_cnt), 32'd0);

        // Same-cycle A/B collision: B wins, both in bypass and in storage.
        set_rd(5'd7, 5'd7);
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        #1;
        chk("bypass_r7", rd_data[31:0], 32'h22);
        tick();
        idle();
        #1;
        chk("stored_r7_p0", rd_data[31:0], 32'h22);
        chk("stored_r7_p1", rd_data[63:32], 32'h22);

        // Zero register: write and issue r0 together.
        set_rd(5'd0, 5'd0);
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        chk("zero_bypass", rd_data[31:0], 32'd0);
        tick();
        idle();
        #1;
        chk("zero_rd", rd_data[31:0], 32'd0);
        chk("zero_busy", 32'(rd_busy), 32'd0);
        chk("zero_cnt", 32'(busy_cnt), 32'd0);
        chk("nz_r0_data", nz_rd_data[31:0], 32'h55);
        chk("nz_r0_busy", 32'(nz_rd_busy[0]), 32'd1);
        chk("nz_r0_cnt", 32'(nz_busy_cnt), 32'd1);

        // Scoreboard lifecycle on r3.
        set_rd(5'd3, 5'd0);
        iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        chk("iss_same_cycle_busy", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        #1;
        chk("r3_busy", 32'(rd_busy[0]), 32'd1);
        chk("r3_cnt", 32'(busy_cnt), 32'd1);
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h99;
        #1;
        chk("r3_wr_busy", 32'(rd_busy[0]), 32'd0);
        chk("r3_wr_data", rd_data[31:0], 32'h99);
        tick();
        idle();
        #1;
        chk("r3_free_cnt", 32'(busy_cnt), 32'd0);
        chk("r3_free_busy", 32'(rd_busy[0]), 32'd0);

        // Simultaneous issue/write on r4, write on r9.
        set_rd(5'd4, 5'd9);
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        iss_addr = 5'd9;
        tick();
        idle();
        #1;
        chk("sim_busy_both", 32'(rd_busy), 32'd3);
        chk("sim_cnt2", 32'(busy_cnt), 32'd2);
        iss_en = 1'b1; iss_addr = 5'd4;
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hA4;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hB9;
        #1;
        chk("sim_bypass_busy", 32'(rd_busy), 32'd0);
        tick();
        idle();
        #1;
        chk("sim_busy_after", 32'(rd_busy), 32'd1);
        chk("sim_cnt1", 32'(busy_cnt), 32'd1);
        chk("sim_r4", rd_data[31:0], 32'hA4);
        chk("sim_r9", rd_data[63:32], 32'hB9);
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hC4;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hC9;
        tick();
        idle();
        #1;
        chk("sim_cnt0", 32'(busy_cnt), 32'd0);
        chk("sim_busy0", 32'(rd_busy), 32'd0);

        // Both ports clearing the same busy register must decrement once.
        set_rd(5'd10, 5'd0);
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        idle();
        wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h1A;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h2A;
        tick();
        idle();
        #1;
        chk("dual_clear_cnt", 32'(busy_cnt), 32'd0);
        chk("dual_clear_data", rd_data[31:0], 32'h2A);

        // Capacity: fill r1..r31, then drain two per cycle.
        for (int i = 1; i <= 31; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            tick();
        end
        idle();
        #1;
        chk("cap_full_cnt", 32'(busy_cnt), 32'd31);
        for (int i = 1; i <= 31; i += 2) begin
            wa_en = 1'b1; wa_addr = 5'(i); wa_data = 32'(i);
            wb_en = (i + 1 <= 31); wb_addr = 5'(i + 1); wb_data = 32'(i + 1);
            tick();
            if (i == 1) begin
                chk("cap_first_drain", 32'(busy_cnt), 32'd29);
            end
        end
        idle();
        set_rd(5'd31, 5'd16);
        #1;
        chk("cap_empty_cnt", 32'(busy_cnt), 32'd0);
        chk("cap_r31", rd_data[31:0], 32'd31);
        chk("cap_r16", rd_data[63:32], 32'd16);
        chk("cap_busy", 32'(rd_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
